// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: validates and commits moves, alternates turns, and detects win/draw.
// Optional macro TURN_TIMEOUT_EN adds a per-turn time limit that passes the move to the other player.
module ttt_game_ctrl #(
  parameter int unsigned CLK_DIV    = 25000,
  parameter int unsigned TIMEOUT_MS = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic        is_main,
  output logic        view_right,
  output logic [3:0]  move_count,
  output logic        move_reject
);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

  state_t      state, state_n;
  logic [17:0] board_n;
  logic        turn_n;
  logic [1:0]  result_n;
  logic        view_n;
  logic [3:0]  count_n;
  logic        reject_n;

  logic [8:0]  x_plane, o_plane, mover_plane;
  logic [3:0]  key_idx, count_inc;
  logic        is_cell, is_restart, occupied, mover_wins;
  logic        timeout;

  // Cells are indexed 0..8 in row-major order (cell 1 = index 0).
  function automatic logic has_line(input logic [8:0] p);
    return (p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]) | (p[6] & p[7] & p[8]) |
           (p[0] & p[3] & p[6]) | (p[1] & p[4] & p[7]) | (p[2] & p[5] & p[8]) |
           (p[0] & p[4] & p[8]) | (p[2] & p[4] & p[6]);
  endfunction

  always_comb begin
    for (int c = 0; c < 9; c++) begin
      x_plane[c] = board[16-2*c];
      o_plane[c] = board[17-2*c];
    end
  end

  assign key_idx     = key_code - 4'd1;
  assign is_cell     = key_valid && (key_code >= 4'd1) && (key_code <= 4'd9);
  assign is_restart  = key_valid && (key_code == 4'd0);
  assign occupied    = x_plane[key_idx] | o_plane[key_idx];
  assign mover_plane = turn_o ? o_plane : x_plane;
  assign mover_wins  = has_line(mover_plane);
  assign count_inc   = (move_count >= 4'd9) ? 4'd9 : move_count + 4'd1;
  assign is_main     = (state == IDLE);

`ifdef TURN_TIMEOUT_EN
  int unsigned prescale, prescale_n, ms_cnt, ms_n;
  logic        tick;

  assign tick    = (prescale == CLK_DIV - 1);
  assign timeout = (state == PLAY) && tick && (ms_cnt == TIMEOUT_MS - 1);

  // The timer only runs while staying in PLAY; any restart, timeout or exit starts it over.
  always_comb begin
    prescale_n = 0;
    ms_n       = 0;
    if (state == PLAY && state_n == PLAY && !is_restart && !timeout) begin
      if (tick) begin
        ms_n = ms_cnt + 1;
      end else begin
        prescale_n = prescale + 1;
        ms_n       = ms_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= 0;
      ms_cnt   <= 0;
    end else begin
      prescale <= prescale_n;
      ms_cnt   <= ms_n;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (CLK_DIV == 0) ^ (TIMEOUT_MS == 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    board_n  = board;
    turn_n   = turn_o;
    result_n = result;
    count_n  = move_count;
    reject_n = 1'b0;
    view_n   = view_right;

    if (key_valid && key_code == 4'd10) begin
      view_n = 1'b0;
    end else if (key_valid && key_code == 4'd11) begin
      view_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (game_en) begin
          state_n  = PLAY;
          board_n  = '0;
          count_n  = '0;
          result_n = 2'b00;
          turn_n   = 1'b0;
        end
      end
      PLAY: begin
        if (is_restart) begin
          board_n  = '0;
          count_n  = '0;
          result_n = 2'b00;
          turn_n   = 1'b0;
        end else if (is_cell) begin
          if (occupied) begin
            reject_n = 1'b1;
          end else begin
            for (int c = 0; c < 9; c++) begin
              if (key_idx == 4'(c)) begin
                if (turn_o) board_n[17-2*c] = 1'b1;
                else        board_n[16-2*c] = 1'b1;
              end
            end
            state_n = CHECK;
          end
        end else if (timeout) begin
          turn_n = ~turn_o;
        end
      end
      // A completed line on the ninth stone counts as a win, not a draw.
      CHECK: begin
        count_n = count_inc;
        if (mover_wins) begin
          result_n = turn_o ? 2'b10 : 2'b01;
          state_n  = DONE;
        end else if (count_inc == 4'd9) begin
          result_n = 2'b11;
          state_n  = DONE;
        end else begin
          turn_n  = ~turn_o;
          state_n = PLAY;
        end
      end
      DONE: begin
        if (is_restart) begin
          board_n  = '0;
          count_n  = '0;
          result_n = 2'b00;
          turn_n   = 1'b0;
          state_n  = PLAY;
        end
      end
      default: state_n = IDLE;
    endcase

    // Leaving game mode wins over anything else decided this cycle.
    if (state != IDLE && !game_en) begin
      state_n  = IDLE;
      board_n  = '0;
      result_n = 2'b00;
      count_n  = '0;
      turn_n   = 1'b0;
      reject_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      board       <= '0;
      turn_o      <= 1'b0;
      result      <= 2'b00;
      view_right  <= 1'b0;
      move_count  <= '0;
      move_reject <= 1'b0;
    end else begin
      state       <= state_n;
      board       <= board_n;
      turn_o      <= turn_n;
      result      <= result_n;
      view_right  <= view_n;
      move_count  <= count_n;
      move_reject <= reject_n;
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl; the timer section runs only when TURN_TIMEOUT_EN is defined.
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_en;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic        is_main;
  logic        view_right;
  logic [3:0]  move_count;
  logic        move_reject;

  int checks = 0;
  int errors = 0;
  int draw_seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
  int win9_seq[9] = '{1, 2, 3, 5, 4, 6, 8, 9, 7};

  always #5 clk = ~clk;

  ttt_game_ctrl #(.CLK_DIV(4), .TIMEOUT_MS(3)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .key_valid(key_valid), .key_code(key_code),
    .board(board), .turn_o(turn_o), .result(result), .is_main(is_main),
    .view_right(view_right), .move_count(move_count), .move_reject(move_reject)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presses one key for a single clock; returns at the negedge right after it was sampled.
  task automatic applyStimulus(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic playMove(input logic [3:0] code);
    applyStimulus(code);
    step(1);
  endtask

  initial begin
    rst = 1'b0; game_en = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    @(negedge clk);
    step(2);
    checkOutput("rst_board", board, 0);
    checkOutput("rst_turn", turn_o, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_main", is_main, 1);
    checkOutput("rst_view", view_right, 0);
    checkOutput("rst_count", move_count, 0);
    checkOutput("rst_reject", move_reject, 0);

    rst = 1'b1;
    step(1);
    checkOutput("idle_main", is_main, 1);
    game_en = 1'b1;
    step(1);
    checkOutput("play_main", is_main, 0);

    applyStimulus(4'd1);
    checkOutput("m1_board", board, 18'h10000);
    checkOutput("m1_turn_n1", turn_o, 0);
    checkOutput("m1_reject", move_reject, 0);
    step(1);
    checkOutput("m1_turn_n2", turn_o, 1);
    checkOutput("m1_result", result, 0);
    checkOutput("m1_count", move_count, 1);

    playMove(4'd4); playMove(4'd2); playMove(4'd5); playMove(4'd3);
    checkOutput("xwin_result", result, 2'b01);
    checkOutput("xwin_board", board, 18'h15A00);
    checkOutput("xwin_count", move_count, 5);
    applyStimulus(4'd6);
    checkOutput("done_board", board, 18'h15A00);
    checkOutput("done_reject", move_reject, 0);
    step(1);

    applyStimulus(4'd0);
    checkOutput("rs_board", board, 0);
    checkOutput("rs_result", result, 0);
    checkOutput("rs_turn", turn_o, 0);
    checkOutput("rs_count", move_count, 0);

    playMove(4'd5);
    applyStimulus(4'd5);
    checkOutput("rej_pulse", move_reject, 1);
    checkOutput("rej_board", board, 18'h00100);
    checkOutput("rej_turn", turn_o, 1);
    step(1);
    checkOutput("rej_pulse_end", move_reject, 0);
    checkOutput("rej_turn_hold", turn_o, 1);
    checkOutput("rej_count", move_count, 1);

    applyStimulus(4'd0);
    checkOutput("prs_board", board, 0);
    checkOutput("prs_turn", turn_o, 0);

    for (int i = 0; i < 9; i++) playMove(4'(draw_seq[i]));
    checkOutput("draw_result", result, 2'b11);
    checkOutput("draw_count", move_count, 9);
    checkOutput("draw_board", board, 18'h196A5);

    applyStimulus(4'd0);
    for (int i = 0; i < 9; i++) playMove(4'(win9_seq[i]));
    checkOutput("win9_result", result, 2'b01);
    checkOutput("win9_count", move_count, 9);
    checkOutput("win9_turn", turn_o, 0);
    checkOutput("win9_board", board, 18'h19696);

    applyStimulus(4'd0);
    applyStimulus(4'd1);
    rst = 1'b0;
    step(1);
    checkOutput("rchk_board", board, 0);
    checkOutput("rchk_turn", turn_o, 0);
    checkOutput("rchk_result", result, 0);
    checkOutput("rchk_count", move_count, 0);
    checkOutput("rchk_main", is_main, 1);
    rst = 1'b1;
    step(1);
    checkOutput("rchk_play", is_main, 0);

    playMove(4'd1);
    checkOutput("gen_board_pre", board, 18'h10000);
    game_en = 1'b0;
    step(1);
    checkOutput("gen_main", is_main, 1);
    checkOutput("gen_board", board, 0);

    applyStimulus(4'd11);
    checkOutput("view_hash_idle", view_right, 1);
    applyStimulus(4'd12);
    checkOutput("code12_view", view_right, 1);
    checkOutput("code12_main", is_main, 1);
    game_en = 1'b1;
    step(1);
    applyStimulus(4'd10);
    checkOutput("view_star_play", view_right, 0);
    checkOutput("view_star_board", board, 0);

`ifdef TURN_TIMEOUT_EN
    game_en = 1'b0;
    step(1);
    game_en = 1'b1;
    step(1);
    step(11);
    checkOutput("tmo_before", turn_o, 0);
    step(1);
    checkOutput("tmo_turn", turn_o, 1);
    checkOutput("tmo_board", board, 0);
    checkOutput("tmo_count", move_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
